// File: rtl/hamming_enc_arbiter_pkg.sv
// Shared constants and types for the Hamming(15,11) encoder/arbiter slice.
package hamming_enc_arbiter_pkg;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned CODE_W = 15;

    // Codeword indices (Hamming position - 1) that carry parity bits
    localparam int unsigned P0_POS = 0;
    localparam int unsigned P1_POS = 1;
    localparam int unsigned P3_POS = 3;
    localparam int unsigned P7_POS = 7;

    // Data bits covered by each parity bit
    localparam logic [DATA_W-1:0] P0_MASK = 11'h55B; // d0 d1 d3 d4 d6 d8 d10
    localparam logic [DATA_W-1:0] P1_MASK = 11'h66D; // d0 d2 d3 d5 d6 d9 d10
    localparam logic [DATA_W-1:0] P3_MASK = 11'h78E; // d1 d2 d3 d7 d8 d9 d10
    localparam logic [DATA_W-1:0] P7_MASK = 11'h7F0; // d4..d10

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/hamming_enc_arbiter_enc.sv
// Combinational Hamming(15,11) encoder; code bit i is Hamming position i+1.
module hamming1511_enc
    import hamming_enc_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CODE_W-1:0] o_code
);

    // Place data bits in non-power-of-two positions and compute parity
    always_comb begin
        o_code          = '0;
        o_code[2]       = i_data[0];
        o_code[6:4]     = i_data[3:1];
        o_code[14:8]    = i_data[10:4];
        o_code[P0_POS]  = ^(i_data & P0_MASK);
        o_code[P1_POS]  = ^(i_data & P1_MASK);
        o_code[P3_POS]  = ^(i_data & P3_MASK);
        o_code[P7_POS]  = ^(i_data & P7_MASK);
    end

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Two-requester round-robin arbiter feeding one shared Hamming(15,11)
// encoder into a single registered output with valid/ready handshake.
module hamming_enc_arbiter
    import hamming_enc_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in0_valid,
    input  logic [DATA_W-1:0]    in0_data,
    output logic                 in0_ready,
    input  logic                 in1_valid,
    input  logic [DATA_W-1:0]    in1_data,
    output logic                 in1_ready,
    output logic                 out_valid,
    output logic [CODE_W-1:0]    out_code,
    output logic                 out_src,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                r_src;
    logic [CODE_W-1:0]   r_code;
    logic [CNT_W-1:0]    r_cnt0;
    logic [CNT_W-1:0]    r_cnt1;

    logic                w_gnt;
    logic                w_any_valid;
    logic                w_can_load;
    logic                w_accept;
    logic [DATA_W-1:0]   w_data;
    logic [CODE_W-1:0]   w_code;

    // Round-robin grant: on contention the requester not served last wins
    always_comb begin
        w_gnt = 1'b0;
        if (in0_valid && in1_valid) begin
            w_gnt = ~r_last;
        end else if (in1_valid) begin
            w_gnt = 1'b1;
        end
    end

    assign w_any_valid = in0_valid | in1_valid;
    // rst_n gating keeps both readies low for the whole reset window
    assign w_can_load  = rst_n & en & ((r_state == EMPTY) | out_ready);
    assign w_accept    = w_can_load & w_any_valid;
    assign w_data      = w_gnt ? in1_data : in0_data;

    hamming1511_enc u_enc (
        .i_data (w_data),
        .o_code (w_code)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, output-valid and ready decode
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        in0_ready   = 1'b0;
        in1_ready   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (w_accept) begin
                    w_state_nxt = FULL;
                end else if (out_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (w_accept) begin
            in0_ready = ~w_gnt;
            in1_ready = w_gnt;
        end
    end

    // Output codeword register and last-granted pointer, loaded on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= '0;
            r_src  <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_code <= w_code;
            r_src  <= w_gnt;
            r_last <= w_gnt;
        end
    end

    // Saturating per-requester acceptance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_gnt && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_gnt && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign out_code = r_code;
    assign out_src  = r_src;
    assign cnt0     = r_cnt0;
    assign cnt1     = r_cnt1;

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Scoreboard bench for hamming_enc_arbiter: directed stimulus pushes
// hand-computed codewords, a negedge monitor pops them on each handshake.
module tb_hamming_enc_arbiter;

    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic        src;
        logic [14:0] code;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              in0_valid;
    logic [10:0]       in0_data;
    logic              in0_ready;
    logic              in1_valid;
    logic [10:0]       in1_data;
    logic              in1_ready;
    logic              out_valid;
    logic [14:0]       out_code;
    logic              out_src;
    logic              out_ready;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [10:0] sat_d [5];
    logic [14:0] sat_c [5];

    hamming_enc_arbiter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_src   (out_src),
        .out_ready (out_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic s, input logic [14:0] c);
        exp_t e;
        e.src  = s;
        e.code = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
    endtask

    // Asynchronous reset pulse in mid-cycle; held words are discarded
    task automatic do_reset(input bit expect_drained);
        if (expect_drained) check("drained_before_reset", 32'(exp_q.size()), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_code", 32'(out_code), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        check("rst_rdy", 32'({in0_ready, in1_ready}), 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: compare every handshaked output word against the scoreboard
    always @(negedge clk) begin
        check("onehot_ready", 32'(in0_ready & in1_ready), 32'd0);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(out_code), 32'h7FFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_code", 32'(out_code), 32'(e.code));
                check("out_src", 32'(out_src), 32'(e.src));
            end
        end
    end

    initial begin
        sat_d[0] = 11'h001; sat_c[0] = 15'h0007;
        sat_d[1] = 11'h002; sat_c[1] = 15'h0019;
        sat_d[2] = 11'h400; sat_c[2] = 15'h408B;
        sat_d[3] = 11'h010; sat_c[3] = 15'h0181;
        sat_d[4] = 11'h7FF; sat_c[4] = 15'h7FFF;

        rst_n = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        #12;
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_code", 32'(out_code), 32'd0);
        check("init_cnt", 32'({cnt0, cnt1}), 32'd0);
        check("init_rdy", 32'({in0_ready, in1_ready}), 32'd0);
        tick();
        rst_n = 1'b1;
        en = 1'b1;

        // Single word from in0
        out_ready = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 11'h001;
        push(1'b0, 15'h0007);
        #1;
        check("s1_rdy0", 32'(in0_ready), 32'd1);
        check("s1_rdy1", 32'(in1_ready), 32'd0);
        tick();
        idle_inputs();
        check("s1_valid", 32'(out_valid), 32'd1);
        check("s1_cnt0", 32'(cnt0), 32'd1);
        tick();
        check("s1_empty", 32'(out_valid), 32'd0);

        // Simultaneous requests from reset: in0 first, in1 next cycle
        do_reset(1'b1);
        in0_valid = 1'b1; in0_data = 11'h010;
        in1_valid = 1'b1; in1_data = 11'h7FF;
        push(1'b0, 15'h0181);
        push(1'b1, 15'h7FFF);
        #1;
        check("s2_rdy0", 32'(in0_ready), 32'd1);
        check("s2_rdy1", 32'(in1_ready), 32'd0);
        tick();
        in0_valid = 1'b0;
        #1;
        check("s2_rdy1_next", 32'(in1_ready), 32'd1);
        tick();
        idle_inputs();
        check("s2_cnts", 32'({cnt0, cnt1}), 32'({2'd1, 2'd1}));
        tick();
        check("s2_empty", 32'(out_valid), 32'd0);

        // Continuous contention alternates grants
        do_reset(1'b1);
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 11'h400;
        in1_valid = 1'b1; in1_data = 11'h002;
        push(1'b0, 15'h408B);
        push(1'b1, 15'h0019);
        push(1'b0, 15'h408B);
        push(1'b1, 15'h0019);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("s3_rdy0", 32'(in0_ready), 32'(k % 2 == 0));
            check("s3_rdy1", 32'(in1_ready), 32'(k % 2 == 1));
            tick();
        end
        idle_inputs();
        check("s3_cnts", 32'({cnt0, cnt1}), 32'({2'd2, 2'd2}));
        tick();

        // Back-pressure: held word stable, no readies, counters frozen
        do_reset(1'b1);
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 11'h002;
        push(1'b0, 15'h0019);
        tick();
        in1_valid = 1'b1; in1_data = 11'h400;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("s4_code", 32'(out_code), 32'h0019);
            check("s4_valid", 32'(out_valid), 32'd1);
            check("s4_rdy", 32'({in0_ready, in1_ready}), 32'd0);
            check("s4_cnts", 32'({cnt0, cnt1}), 32'({2'd1, 2'd0}));
            tick();
        end
        out_ready = 1'b1;
        push(1'b1, 15'h408B);
        #1;
        check("s4_rdy1", 32'(in1_ready), 32'd1);
        tick();
        idle_inputs();
        tick();
        check("s4_cnts_end", 32'({cnt0, cnt1}), 32'({2'd1, 2'd1}));

        // Mid-stream reset while FULL; pointer returns to requester 0
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 11'h001;
        tick();
        in1_valid = 1'b1; in1_data = 11'h400;
        check("s5_full", 32'(out_valid), 32'd1);
        do_reset(1'b0);
        out_ready = 1'b1;
        in0_data = 11'h002;
        push(1'b0, 15'h0019);
        #1;
        check("s5_rdy0", 32'(in0_ready), 32'd1);
        check("s5_rdy1", 32'(in1_ready), 32'd0);
        tick();
        idle_inputs();
        tick();

        // Counter saturation with a 2-bit counter
        do_reset(1'b1);
        out_ready = 1'b1;
        in0_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in0_data = sat_d[k];
            push(1'b0, sat_c[k]);
            #1;
            check("s6_cnt0_pre", 32'(cnt0), 32'((k < 3) ? k : 3));
            tick();
        end
        in0_valid = 1'b0;
        check("s6_cnt0_sat", 32'(cnt0), 32'd3);
        tick();

        // en low while FULL: held word drains, nothing accepted
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 11'h010;
        push(1'b0, 15'h0181);
        tick();
        en = 1'b0;
        in1_valid = 1'b1; in1_data = 11'h7FF;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("s7_rdy_hold", 32'({in0_ready, in1_ready}), 32'd0);
            check("s7_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("s7_rdy_drain", 32'({in0_ready, in1_ready}), 32'd0);
        tick();
        check("s7_empty", 32'(out_valid), 32'd0);
        check("s7_rdy_empty", 32'({in0_ready, in1_ready}), 32'd0);
        check("s7_cnts", 32'({cnt0, cnt1}), 32'({2'd3, 2'd0}));
        idle_inputs();
        en = 1'b1;
        tick();
        tick();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_enc_arbiter.md
HAMMING_ENC_ARBITER -- requirements
Module: hamming_enc_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each per-requester accepted-word counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1: when low, no new words are accepted; a held output still drains.
REQ-005 SHALL have ports in0_valid/in1_valid, input, 1 each: requester word present.
REQ-006 SHALL have ports in0_data/in1_data, input, 11 each: requester data bits d[10:0].
REQ-007 SHALL have ports in0_ready/in1_ready, output, 1 each: word accepted when valid and ready are both high at a clock edge.
REQ-008 SHALL have port out_valid, output, 1: codeword register holds a valid word.
REQ-009 SHALL have port out_code, output, 15: registered Hamming(15,11) codeword.
REQ-010 SHALL have port out_src, output, 1: index of the requester that produced out_code.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_code when out_valid and out_ready are both high.
REQ-012 SHALL have ports cnt0/cnt1, output, CNT_W each: words accepted per requester.

Function
REQ-013 SHALL encode each accepted word through one shared encoder; codeword bit i corresponds to Hamming position i+1.
REQ-014 Parity bit code[0] SHALL be d0^d1^d3^d4^d6^d8^d10.
REQ-015 Parity bit code[1] SHALL be d0^d2^d3^d5^d6^d9^d10.
REQ-016 Parity bit code[3] SHALL be d1^d2^d3^d7^d8^d9^d10.
REQ-017 Parity bit code[7] SHALL be d4..d10 XORed together.
REQ-018 Data bits SHALL map as code[2]=d0, code[6:4]=d3:d1, code[14:8]=d10:d4.
REQ-019 FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 can_load SHALL be en && (state==EMPTY || out_ready).
REQ-021 Grant SHALL be round-robin over requesters with valid high; with both valid, the requester not granted last wins; with one valid, that requester wins.
REQ-022 in<g>_ready SHALL be high only for the granted requester g and only while can_load; at most one ready is high per cycle.
REQ-023 On acceptance, the block SHALL load out_code, out_src=g and set state FULL; the output appears one cycle after the accepting edge.
REQ-024 In FULL with out_ready high and a new acceptance in the same cycle, the block SHALL replace the register and stay FULL, giving one word per cycle throughput.
REQ-025 In FULL with out_ready high and no acceptance, the block SHALL go to EMPTY.
REQ-026 In FULL with out_ready low, out_code and out_src SHALL hold stable and both readies SHALL be low.
REQ-027 The last-granted pointer SHALL update only on acceptance.
REQ-028 cnt<g> SHALL increment on each acceptance from requester g and saturate at all-ones without wrapping.
REQ-029 en falling while FULL SHALL not drop the held word; no acceptance occurs until en returns high.

Reset
REQ-030 Asserting rst_n low SHALL immediately clear state to EMPTY, out_valid=0, out_code=0, out_src=0, last-granted=1 (requester 0 wins first), cnt0=cnt1=0, regardless of any operation in progress.
REQ-031 Readies SHALL be low while rst_n is low; normal operation SHALL begin on the first clock edge after release.

Structure
REQ-032 Shared package SHALL hold DATA_W=11, CODE_W=15, the parity-position constants, and the state enum {EMPTY, FULL}.
REQ-033 The encoder SHALL be one combinational sub-module, hamming1511_enc (11 in, 15 out), instantiated once.

Verification
REQ-034 Scenario: in0 sends 11'h001 with out_ready=1 -> next cycle out_code=15'h0007, out_src=0, cnt0=1.
REQ-035 Scenario: in1 sends 11'h7FF and in0 sends 11'h010 in the same cycle, starting from reset -> in0 is served first (15'h0181, src 0), then in1 (15'h7FFF, src 1), on back-to-back cycles.
REQ-036 Scenario: both requesters are continuously valid with out_ready=1 -> grants alternate 0,1,0,1, with one word per cycle.
REQ-037 Scenario: out_ready is held low for 5 cycles while FULL -> out_code is stable, both readies are low, and no counter changes.
REQ-038 Scenario: rst_n is pulsed low mid-stream while FULL -> out_valid=0 and counters=0 asynchronously, and the first word after release goes to requester 0.
REQ-039 Scenario: CNT_W=2 with 5 in0 words -> cnt0 saturates at 3; en=0 -> no ready is asserted while a held word still drains.
